// File: rtl/exn_ctrl_if.sv
// exn_ctrl_if: MEM-stage exception bus between the pipeline and exn_ctrl.
// master = pipeline side (drives MEM flags, irq), slave = exn_ctrl.
interface exn_ctrl_if #(
  parameter int NUM_IRQ = 8
);
  logic [NUM_IRQ-1:0] irq;
  logic               ex_bubble;
  logic               mem_scall;
  logic               mem_udf;
  logic               mem_eret;
  logic               mem_mtsr;
  logic [31:0]        mem_alu_res;
  logic [31:0]        mem_op3;
  logic [31:0]        mem_nextpc;
  logic               mem_w_cr;
  logic [1:0]         mem_cmp_res;
  logic [1:0]         cmp_reg;
  logic               exn;
  logic [5:0]         exn_type;
  logic               eret;
  logic [31:0]        sr_rdata;
  logic [31:0]        elr;
  logic [1:0]         scr;

  modport master (
    output irq, ex_bubble,
    output mem_scall, mem_udf,
    output mem_eret, mem_mtsr,
    output mem_alu_res, mem_op3,
    output mem_nextpc, mem_w_cr,
    output mem_cmp_res, cmp_reg,
    input  exn, exn_type, eret,
    input  sr_rdata, elr, scr
  );

  modport slave (
    input  irq, ex_bubble,
    input  mem_scall, mem_udf,
    input  mem_eret, mem_mtsr,
    input  mem_alu_res, mem_op3,
    input  mem_nextpc, mem_w_cr,
    input  mem_cmp_res, cmp_reg,
    output exn, exn_type, eret,
    output sr_rdata, elr, scr
  );
endinterface

// File: rtl/exn_ctrl.sv
// exn_ctrl: MEM-stage exception arbiter with nested save stack + SRs.
// Ports: clk, rst_n (sync, active-low), bus (exn_ctrl_if.slave).
module exn_ctrl #(
  parameter int                 NUM_IRQ   = 8,
  parameter int                 DEPTH     = 2,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
  parameter logic [31:0]        SR_BASE   = 32'h1000
) (
  input logic       clk,
  input logic       rst_n,
  exn_ctrl_if.slave bus
);

  localparam int DW = 4;
  localparam int RW = (NUM_IRQ < 32) ? NUM_IRQ : 32;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  typedef struct packed {
    logic        sie;
    logic [1:0]  cr;
    logic [31:0] elr;
    logic [31:0] info;
  } ent_t;

  ent_t               stk_q [DEPTH];
  ent_t               stk_d [DEPTH];
  logic               ie_q, ie_d;
  logic [NUM_IRQ-1:0] imask_q, imask_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [DW-1:0]      depth_q, depth_d;

  logic [NUM_IRQ-1:0] pend, act, clr, wdat;
  logic [31:0]        sr_off, rdata;
  logic [31:0]        imask_r, pend_r, info;
  logic [5:0]         irq_sel, etype;
  logic [1:0]         cr_sel;
  logic               sr_hit, ie_wr, true_ie;
  logic               irq_ok, full;
  logic               exn, eret, push;
  logic               take_irq, mtsr_en;
  ent_t               top;

  // Level lines are not stored; only edge lines keep state.
  assign pend   = (pend_q & EDGE_MASK)
                | (bus.irq & ~EDGE_MASK);
  assign act    = pend & imask_q;
  assign sr_off = bus.mem_alu_res - SR_BASE;
  assign sr_hit = sr_off < 32'd8;
  assign ie_wr  = bus.mem_mtsr && sr_hit
                && sr_off[2:0] == 3'd0;
  // IE write in MEM is forwarded into the IRQ decision.
  assign true_ie = ie_wr ? bus.mem_op3[0] : ie_q;
  assign irq_ok  = |act && true_ie
                 && !bus.ex_bubble;
  assign full    = depth_q == FULL;
  assign cr_sel  = bus.mem_w_cr ? bus.mem_cmp_res
                                : bus.cmp_reg;
  assign info    = take_irq ? {26'b0, irq_sel}
                            : bus.mem_alu_res;

  always_comb begin
    irq_sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (act[i]) irq_sel = 6'(i);
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (depth_q == DW'(i + 1)) top = stk_q[i];
    imask_r = '0;
    imask_r[RW-1:0] = imask_q[RW-1:0];
    pend_r = '0;
    pend_r[RW-1:0] = pend[RW-1:0];
    wdat = '0;
    wdat[RW-1:0] = bus.mem_op3[RW-1:0];
  end

  always_comb begin
    exn      = 1'b1;
    eret     = 1'b0;
    etype    = '0;
    push     = 1'b0;
    take_irq = 1'b0;
    priority case (1'b1)
      !rst_n: ;
      bus.mem_scall: begin
        etype = 6'd2;
        push  = 1'b1;
      end
      bus.mem_udf: begin
        etype = 6'd3;
        push  = 1'b1;
      end
      bus.mem_eret: eret = 1'b1;
      irq_ok: begin
        etype    = 6'd8 + irq_sel;
        push     = 1'b1;
        take_irq = 1'b1;
      end
      default: exn = 1'b0;
    endcase
    // Full stack: report double fault, nothing saved.
    if (push && full) etype = 6'd4;
  end

  always_comb begin
    ie_d    = ie_q;
    imask_d = imask_q;
    depth_d = depth_q;
    stk_d   = stk_q;
    clr     = '0;
    mtsr_en = bus.mem_mtsr && !exn && sr_hit;
    if (push) begin
      ie_d = 1'b0;
      if (!full) begin
        for (int i = 0; i < DEPTH; i++)
          if (depth_q == DW'(i))
            stk_d[i] = '{sie:  ie_q,
                         cr:   cr_sel,
                         elr:  bus.mem_nextpc,
                         info: info};
        depth_d = depth_q + 1'b1;
        // Lowest set bit of act == the line taken.
        if (take_irq) clr = act & (~act + 1'b1);
      end
    end else if (eret && depth_q != '0) begin
      ie_d    = top.sie;
      depth_d = depth_q - 1'b1;
    end
    if (mtsr_en) begin
      case (sr_off[2:0])
        3'd0:    ie_d = bus.mem_op3[0];
        3'd5:    imask_d = wdat;
        3'd6:    clr = wdat & EDGE_MASK;
        default: ;
      endcase
      for (int i = 0; i < DEPTH; i++)
        if (depth_q == DW'(i + 1))
          case (sr_off[2:0])
            3'd1:    stk_d[i].sie  = bus.mem_op3[0];
            3'd2:    stk_d[i].cr   = bus.mem_op3[1:0];
            3'd3:    stk_d[i].elr  = bus.mem_op3;
            3'd4:    stk_d[i].info = bus.mem_op3;
            default: ;
          endcase
    end
    // A new edge beats a same-cycle clear.
    pend_d = ((pend_q & ~clr) | (bus.irq & ~irq_q))
           & EDGE_MASK;
  end

  always_comb begin
    rdata = '0;
    if (sr_hit)
      case (sr_off[2:0])
        3'd0:    rdata = {31'b0, ie_q};
        3'd1:    rdata = {31'b0, top.sie};
        3'd2:    rdata = {30'b0, top.cr};
        3'd3:    rdata = top.elr;
        3'd4:    rdata = top.info;
        3'd5:    rdata = imask_r;
        3'd6:    rdata = pend_r;
        default: rdata = {28'b0, depth_q};
      endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ie_q    <= 1'b0;
      imask_q <= '0;
      pend_q  <= '0;
      irq_q   <= '0;
      depth_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        stk_q[i] <= '0;
    end else begin
      ie_q    <= ie_d;
      imask_q <= imask_d;
      pend_q  <= pend_d;
      irq_q   <= bus.irq;
      depth_q <= depth_d;
      stk_q   <= stk_d;
    end
  end

  assign bus.exn      = exn;
  assign bus.exn_type = etype;
  assign bus.eret     = eret;
  assign bus.sr_rdata = rdata;
  assign bus.elr      = top.elr;
  assign bus.scr      = top.cr;

endmodule

// File: doc/exn_ctrl.md
# exn_ctrl

Parametrised successor to the core's exception unit. It arbitrates reset, system-call, undefined-instruction, ERET and `NUM_IRQ` maskable interrupt lines at the MEM stage, and saves exception state on a `DEPTH`-entry stack so handlers can nest. It also holds the exception system registers read and written by MTSR/MFSR. Detection and outputs are combinational in the MEM cycle; all state commits on the following clock edge.

## Interface
- `NUM_IRQ`, 8: interrupt lines, 1..56.
- `DEPTH`, 2: saved-state stack entries, 1..8.
- `EDGE_MASK`, '0: `NUM_IRQ` bits; bit i = 1 makes line i edge-triggered, 0 makes it level-triggered.
- `SR_BASE`, 'h1000: base system-register number.

Ports (clock and reset first):
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `irq` in NUM_IRQ: interrupt lines, already synchronous to `clk`.
- `ex_bubble` in 1: EX holds a bubble; blocks IRQ entry.
- `mem_scall`, `mem_udf`, `mem_eret`, `mem_mtsr` in 1: MEM-stage instruction flags.
- `mem_alu_res` in 32: SR number for MTSR/MFSR; fault info for SCALL/UDF.
- `mem_op3` in 32: MTSR write data.
- `mem_nextpc` in 32: return PC to save.
- `mem_w_cr`, `mem_cmp_res` (2), `cmp_reg` (2) in: compare-flag source, selected as `mem_w_cr ? mem_cmp_res : cmp_reg`.
- `exn` out 1: take exception/ERET redirect this cycle.
- `exn_type` out 6: 0 RST, 2 SCALL, 3 UDF, 4 DFAULT, 8+i IRQ line i.
- `eret` out 1: redirect is an ERET.
- `sr_rdata` out 32: SR read data for `mem_alu_res`.
- `elr` out 32, `scr` out 2: ELR and CR fields of the top stack entry; 0 when the stack is empty.

## Operation
- System-register map:
  - `SR_BASE+0` IE, rw.
  - `+1` SIE, top entry, rw.
  - `+2` SCR, top entry, rw.
  - `+3` ELR, top entry, rw.
  - `+4` EINFO, top entry, rw.
  - `+5` IMASK, rw, `NUM_IRQ` bits.
  - `+6` IPEND: reads `pend`; a write clears edge-line pending bits where the written bit is 1.
  - `+7` DEPTH, read-only, number of stack entries in use.
  - Unmapped numbers read 0 and ignore writes. Writes to top-entry SRs while the stack is empty are ignored.
- Pending state:
  - Level line: `pend[i] = irq[i]`, not stored.
  - Edge line: `pend[i]` sets on `irq[i] & ~irq_q[i]`. It clears when IRQ i is taken or on an IPEND write-1.
  - If a set and a clear happen in the same cycle, the set wins.
- Effective IE: `true_ie` is `mem_op3[0]` when the MEM instruction is an MTSR to IE; otherwise it is IE. IMASK writes are not forwarded.
- Priority, highest first:
  - `!rst_n` → RST.
  - SCALL.
  - UDF.
  - ERET, which sets `eret=1`.
  - IRQ, taken when `|(pend & IMASK) && true_ie && !ex_bubble`. The lowest-index active line wins.
- Exception entry (any non-ERET, non-RST exception) when DEPTH < `DEPTH`:
  - Push {IE, selected CR, `mem_nextpc`, info}. Info is `mem_alu_res` for SCALL/UDF and the line index for IRQ.
  - Set IE to 0 and increment DEPTH.
- Entry with a full stack: `exn_type` is DFAULT instead of the requested type. No push; the top entry is unchanged; IE is set to 0. An IRQ that is overridden this way keeps its pending bit.
- ERET: IE takes the top entry's SIE, and DEPTH decrements. With DEPTH = 0, `exn` and `eret` are still 1, IE is unchanged, and `elr` is 0.
- MTSR takes effect only when `exn` is 0.

## Timing
- `exn`, `exn_type`, `eret`, `sr_rdata`, `elr` and `scr` are combinational in the same cycle as the MEM-stage inputs.
- The stack, IE, IMASK, `pend` and `irq_q` update at the next rising edge.
- An edge arriving in cycle t makes `pend` high in cycle t+1, so the IRQ can be taken no earlier than t+1.
- While `rst_n` is low: `exn`=1 and `exn_type`=0. At each clock edge, IE, IMASK, `pend`, `irq_q` and DEPTH are cleared and stack contents are zeroed. No push happens.
- A line that is high when reset is released counts as an edge one cycle later.
- Back-to-back exceptions in consecutive cycles push twice.

## Test plan
- Reset, then set IE=1 and IMASK=0x05, and drive `irq`=0x05 (level) → `exn`, `exn_type`=8, EINFO=0, DEPTH=1, IE=0.
- Edge line 3 (`EDGE_MASK`=0x08): pulse `irq[3]` for 1 cycle with IE=0 → IPEND=0x08. Set IE=1 → `exn_type`=11 and IPEND=0. Repeat with an IPEND write of 0x08 instead → no exception.
- `DEPTH`=2: SCALL with `alu_res`=0x55, then UDF, then SCALL → types 2, 3, then 4. DEPTH stays 2, and ELR keeps the UDF's `nextpc`.
- Two nested SCALLs, then two ERETs → ELR steps back to the first `nextpc`, and IE returns to 1.
- ERET at DEPTH 0 → `exn`=`eret`=1, IE unchanged.
- MTSR IE=1 in the same cycle a masked-in IRQ is pending, with `ex_bubble`=0 → IRQ taken and the MTSR dropped. The same case with `ex_bubble`=1 → no exception and IE=1.
